// File: rtl/bridge_pkg.sv
// Shared constants for the UART-to-CPU bridge: state encoding, default
// command bytes and the UART byte width.
package bridge_pkg;

  localparam int UART_W = 8;

  localparam logic [7:0] CMD_RUN_DEF    = 8'h01;
  localparam logic [7:0] CMD_RESEND_DEF = 8'h02;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_SEND    = 2'd2;
  localparam logic [1:0] ST_WAIT_TX = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_RUN     = ST_RUN,
    S_SEND    = ST_SEND,
    S_WAIT_TX = ST_WAIT_TX
  } state_t;

endpackage

// File: rtl/rise_detect.sv
// One-bit rising-edge detector: a held-high level yields a single event,
// asserted in the first cycle the input is seen high.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= i_sig;
  end

  assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/uart_cpu_bridge.sv
// Decodes host command bytes, launches a CPU run, snapshots the result words
// and streams them to the UART TX byte by byte (word 0 first, LSB first).
module uart_cpu_bridge
  import bridge_pkg::*;
#(
  parameter int         NBIT_DATA_LEN = UART_W,
  parameter int         NBIT_WORD_LEN = 16,
  parameter int         N_WORDS       = 3,
  parameter logic [7:0] CMD_RUN       = CMD_RUN_DEF,
  parameter logic [7:0] CMD_RESEND    = CMD_RESEND_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rx_done_tick,
  input  logic [NBIT_DATA_LEN-1:0]         rx_data_in,
  input  logic                             tx_done_tick,
  input  logic [N_WORDS*NBIT_WORD_LEN-1:0] result_in,
  input  logic                             cpu_done,
  output logic                             cpu_start,
  output logic                             tx_start,
  output logic [NBIT_DATA_LEN-1:0]         data_out,
  output logic                             busy,
  output logic [1:0]                       o_dbg_state
);

  localparam int SNAP_W      = N_WORDS * NBIT_WORD_LEN;
  localparam int TOTAL_BYTES = SNAP_W / 8;
  localparam int IDX_W       = (TOTAL_BYTES > 1) ? $clog2(TOTAL_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_BYTES - 1);

  if ((NBIT_WORD_LEN % 8) != 0 || N_WORDS < 1 || NBIT_DATA_LEN != 8) begin : g_param_check
    $error("uart_cpu_bridge: NBIT_WORD_LEN must be a multiple of 8, N_WORDS >= 1, NBIT_DATA_LEN == 8");
  end

  // Handshake: the three *_done/_tick inputs carry no ready; each rising edge
  // is one event, consumed only in the state that expects it, otherwise dropped.
  logic w_rx_ev, w_tx_ev, w_cpu_ev;

  rise_detect u_rx_edge  (.clk(clk), .rst(rst), .i_sig(rx_done_tick), .o_rise(w_rx_ev));
  rise_detect u_tx_edge  (.clk(clk), .rst(rst), .i_sig(tx_done_tick), .o_rise(w_tx_ev));
  rise_detect u_cpu_edge (.clk(clk), .rst(rst), .i_sig(cpu_done),     .o_rise(w_cpu_ev));

  state_t                   r_state, w_state_nxt;
  logic [SNAP_W-1:0]        r_snapshot;
  logic [IDX_W-1:0]         r_idx, w_idx_nxt;
  logic [NBIT_DATA_LEN-1:0] r_data, w_data_nxt, w_byte;
  logic [IDX_W+2:0]         w_byte_base;
  logic                     r_cpu_start, r_tx_start, r_busy;
  logic                     w_cpu_start_nxt, w_tx_start_nxt, w_snap_load;

  assign w_byte_base = {r_idx, 3'b000};
  assign w_byte      = r_snapshot[w_byte_base +: NBIT_DATA_LEN];

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_data_nxt      = r_data;
    w_cpu_start_nxt = 1'b0;
    w_tx_start_nxt  = 1'b0;
    w_snap_load     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rx_ev) begin
          if (rx_data_in == CMD_RUN) begin
            w_state_nxt     = S_RUN;
            w_cpu_start_nxt = 1'b1;
          end else if (rx_data_in == CMD_RESEND) begin
            w_state_nxt = S_SEND;
            w_idx_nxt   = '0;
          end
        end
      end
      S_RUN: begin
        if (w_cpu_ev) begin
          w_snap_load = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        w_data_nxt     = w_byte;
        w_tx_start_nxt = 1'b1;
        w_state_nxt    = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (w_tx_ev) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = S_SEND;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_data      <= '0;
      r_snapshot  <= '0;
      r_cpu_start <= 1'b0;
      r_tx_start  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_data      <= w_data_nxt;
      r_cpu_start <= w_cpu_start_nxt;
      r_tx_start  <= w_tx_start_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      if (w_snap_load) r_snapshot <= result_in;
    end
  end

  assign cpu_start   = r_cpu_start;
  assign tx_start    = r_tx_start;
  assign data_out    = r_data;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule
